// File: rtl/bus_led_seg_slave.sv
// LED / 8-digit seven-segment peripheral on the CPU load/store bus.
// Three word registers plus a free-running digit multiplexer.
module bus_led_seg_slave #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter logic [15:0] SCAN_DIV  = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    logic [15:0] led_q, led_d;
    logic [31:0] seg_q, seg_d;
    logic [15:0] ctl_q, ctl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  an_q, an_d;
    logic [7:0]  cat_q, cat_d;

    logic [31:0] off;
    logic        sel_led, sel_seg, sel_ctl;
    logic [31:0] rd_mux;
    logic [3:0]  digit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Word offset from the base; byte lane bits are ignored.
    assign off     = bus_addr - BASE_ADDR;
    assign sel_led = (off[31:2] == 30'd0);
    assign sel_seg = (off[31:2] == 30'd1);
    assign sel_ctl = (off[31:2] == 30'd2);
    assign digit   = seg_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        led_d    = led_q;
        seg_d    = seg_q;
        ctl_d    = ctl_q;
        rdata_d  = rdata_q;
        rvalid_d = bus_re;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        an_d     = 8'hFF;
        cat_d    = 8'hFF;
        rd_mux   = 32'h0;

        unique case (1'b1)
            sel_led: rd_mux = {16'h0, led_q};
            sel_seg: rd_mux = seg_q;
            sel_ctl: rd_mux = {16'h0, ctl_q};
            default: rd_mux = 32'h0;
        endcase

        // Read mux uses pre-write state, so a same-cycle write returns old data.
        if (bus_re) begin
            rdata_d = rd_mux;
        end

        if (bus_we) begin
            unique case (1'b1)
                sel_led: led_d = bus_wdata[15:0];
                sel_seg: seg_d = bus_wdata;
                sel_ctl: ctl_d = bus_wdata[15:0];
                default: ;
            endcase
        end

        if (ctl_q[0]) begin
            an_d  = ~(8'h01 << idx_q);
            cat_d = {~ctl_q[{1'b1, idx_q}], hex7(digit)};
            if (cnt_q == SCAN_DIV - 16'd1) begin
                cnt_d = 16'd0;
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            cnt_d = 16'd0;
            idx_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q    <= 16'h0;
            seg_q    <= 32'h0;
            ctl_q    <= 16'h0001;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            cnt_q    <= 16'h0;
            idx_q    <= 3'd0;
            an_q     <= 8'hFF;
            cat_q    <= 8'hFF;
        end else begin
            led_q    <= led_d;
            seg_q    <= seg_d;
            ctl_q    <= ctl_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            cat_q    <= cat_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign led        = led_q;
    assign seg_an     = an_q;
    assign seg_cat    = cat_q;

endmodule

// File: tb/tb_bus_led_seg_slave.sv
// Bench for bus_led_seg_slave: cycle model compared every cycle,
// plus directed bus/scan scenarios with literal expectations.
module tb_bus_led_seg_slave;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          DIV  = 4;

    logic        clk;
    logic        rst;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [15:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 0;

    bus_led_seg_slave #(
        .BASE_ADDR(BASE),
        .SCAN_DIV (16'(DIV))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .led       (led),
        .seg_an    (seg_an),
        .seg_cat   (seg_cat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers as plain variables; the scan position is derived
    // arithmetically from the number of enabled clock edges seen so far.
    logic [15:0] m_led    = 16'h0;
    logic [31:0] m_seg    = 32'h0;
    logic [15:0] m_ctl    = 16'h0001;
    logic [31:0] m_rdata  = 32'h0;
    logic        m_rvalid = 1'b0;
    logic [7:0]  m_an     = 8'hFF;
    logic [7:0]  m_cat    = 8'hFF;
    int          m_k      = 0;

    function automatic logic [7:0] hex_lut(input int v);
        case (v)
            0: return 8'hC0;   1: return 8'hF9;
            2: return 8'hA4;   3: return 8'hB0;
            4: return 8'h99;   5: return 8'h92;
            6: return 8'h82;   7: return 8'hF8;
            8: return 8'h80;   9: return 8'h90;
            10: return 8'h88;  11: return 8'h83;
            12: return 8'hC6;  13: return 8'hA1;
            14: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_an(input int k);
        logic [7:0] r;
        r = 8'h01 << ((k / DIV) % 8);
        return ~r;
    endfunction

    function automatic logic [7:0] exp_cat(input int k, input logic [31:0] s,
                                           input logic [15:0] c);
        int d;
        int v;
        logic [7:0] r;
        d = (k / DIV) % 8;
        v = int'((s >> (4 * d)) & 32'hF);
        r = hex_lut(v);
        r[7] = ~c[8 + d];
        return r;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        return (o > 32'd2) ? 3 : int'(o);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (word_of(a))
            0: return {16'h0, m_led};
            1: return m_seg;
            2: return {16'h0, m_ctl};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_led    <= 16'h0;
            m_seg    <= 32'h0;
            m_ctl    <= 16'h0001;
            m_rdata  <= 32'h0;
            m_rvalid <= 1'b0;
            m_an     <= 8'hFF;
            m_cat    <= 8'hFF;
            m_k      <= 0;
        end else begin
            if (m_ctl[0]) begin
                m_an  <= exp_an(m_k);
                m_cat <= exp_cat(m_k, m_seg, m_ctl);
                m_k   <= m_k + 1;
            end else begin
                m_an  <= 8'hFF;
                m_k   <= 0;
            end
            m_rvalid <= bus_re;
            if (bus_re) m_rdata <= m_read(bus_addr);
            if (bus_we) begin
                case (word_of(bus_addr))
                    0: m_led <= bus_wdata[15:0];
                    1: m_seg <= bus_wdata;
                    2: m_ctl <= bus_wdata[15:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_led", {16'h0, led}, {16'h0, m_led});
            chk("cyc_an", {24'h0, seg_an}, {24'h0, m_an});
            if (m_an != 8'hFF) chk("cyc_cat", {24'h0, seg_cat}, {24'h0, m_cat});
            chk("cyc_rvalid", {31'h0, bus_rvalid}, {31'h0, m_rvalid});
            chk("cyc_rdata", bus_rdata, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        tick();
        bus_we    = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a,
                            input logic [31:0] exp);
        bus_addr = a;
        bus_re   = 1'b1;
        tick();
        bus_re   = 1'b0;
        chk({name, "_rvalid"}, {31'h0, bus_rvalid}, 32'h1);
        chk({name, "_rdata"}, bus_rdata, exp);
    endtask

    logic [7:0] scan_cat [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6,
                                 8'h83, 8'h88, 8'h90, 8'h80};

    initial begin
        rst = 1'b1;
        bus_addr = 32'h0;
        bus_wdata = 32'h0;
        bus_we = 1'b0;
        bus_re = 1'b0;
        #3 rst = 1'b0;
        armed = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_an", {24'h0, seg_an}, 32'hFF);
        chk("rst_cat", {24'h0, seg_cat}, 32'hFF);
        rst = 1'b1;
        chk("rel_an", {24'h0, seg_an}, 32'hFF);
        chk("rel_led", {16'h0, led}, 32'h0);
        chk("rel_rvalid", {31'h0, bus_rvalid}, 32'h0);
        tick();
        chk("first_an", {24'h0, seg_an}, 32'hFE);
        chk("first_cat", {24'h0, seg_cat}, 32'hC0);

        bus_write(BASE, 32'h1234_ABCD);
        chk("led_wr", {16'h0, led}, 32'hABCD);
        read_chk("led_rd", BASE, 32'h0000_ABCD);
        tick();
        chk("rvalid_drop", {31'h0, bus_rvalid}, 32'h0);
        chk("rdata_hold", bus_rdata, 32'h0000_ABCD);

        bus_addr  = BASE + 32'd4;
        bus_wdata = 32'h5;
        bus_we    = 1'b1;
        bus_re    = 1'b1;
        tick();
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        chk("rw_old_rdata", bus_rdata, 32'h0);
        chk("rw_rvalid", {31'h0, bus_rvalid}, 32'h1);
        read_chk("rw_new", BASE + 32'd4, 32'h5);

        bus_write(BASE + 32'd4, 32'h89AB_CDEF);
        bus_write(BASE + 32'd8, 32'h0);
        bus_write(BASE + 32'd8, 32'h1);
        tick();
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("scan_an%0d", d), {24'h0, seg_an},
                {24'h0, ~(8'h01 << d)});
            chk($sformatf("scan_cat%0d", d), {24'h0, seg_cat},
                {24'h0, scan_cat[d]});
            repeat (DIV) tick();
        end
        chk("scan_wrap_an", {24'h0, seg_an}, 32'hFE);
        repeat (6) tick();

        bus_write(BASE + 32'd8, 32'h0);
        tick();
        chk("dis_an", {24'h0, seg_an}, 32'hFF);
        repeat (5) tick();
        chk("dis_hold_an", {24'h0, seg_an}, 32'hFF);
        bus_write(BASE + 32'd8, 32'h0101);
        tick();
        chk("reen_an", {24'h0, seg_an}, 32'hFE);
        chk("reen_cat", {24'h0, seg_cat}, 32'h0E);
        repeat (DIV) tick();
        chk("reen_d1_cat", {24'h0, seg_cat}, 32'h86);

        read_chk("pre_unmap", BASE, 32'h0000_ABCD);
        read_chk("unmap", BASE + 32'd12, 32'h0);
        bus_write(BASE + 32'd16, 32'hDEAD_BEEF);
        chk("unmap_wr_led", {16'h0, led}, 32'hABCD);

        bus_re   = 1'b1;
        bus_addr = BASE;
        tick();
        chk("b2b0", bus_rdata, 32'h0000_ABCD);
        bus_addr = BASE + 32'd4;
        tick();
        chk("b2b1", bus_rdata, 32'h89AB_CDEF);
        bus_addr = BASE + 32'd8;
        tick();
        chk("b2b2", bus_rdata, 32'h0000_0101);
        chk("b2b_rvalid", {31'h0, bus_rvalid}, 32'h1);
        bus_re = 1'b0;
        tick();
        chk("b2b_end_rvalid", {31'h0, bus_rvalid}, 32'h0);

        bus_addr = BASE;
        bus_re   = 1'b1;
        tick();
        chk("mid_rvalid", {31'h0, bus_rvalid}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("arst_rvalid", {31'h0, bus_rvalid}, 32'h0);
        chk("arst_rdata", bus_rdata, 32'h0);
        chk("arst_led", {16'h0, led}, 32'h0);
        chk("arst_an", {24'h0, seg_an}, 32'hFF);
        bus_re = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("post_an", {24'h0, seg_an}, 32'hFE);
        read_chk("post_seg", BASE + 32'd4, 32'h0);
        read_chk("post_ctl", BASE + 32'd8, 32'h1);
        repeat (10) tick();

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
